// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: a small byte FIFO feeding an 8N1 serializer
// whose bit period comes from a programmable clock divisor.

module uart_tx_port_div_lane #(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= RST_VAL;
    else if (we) q <= d;
  end

endmodule

module uart_tx_port #(
  parameter logic [15:0] DEFAULT_DIV = 16'd434,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_ce,
  input  logic        ram_wr_en,
  input  logic [31:0] ram_addr,
  input  logic [3:0]  ram_addr_sel,
  input  logic [31:0] ram_wr_data,
  output logic [31:0] ram_data_in,
  output logic        uart_txd
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  typedef struct packed {
    logic        wr;
    logic [1:0]  reg_sel;
    logic [1:0]  be;
    logic [15:0] wdata;
  } bus_req_t;

  bus_req_t req;
  logic     rd_en;

  assign req   = '{wr: ram_ce & ram_wr_en, reg_sel: ram_addr[3:2],
                   be: ram_addr_sel[1:0], wdata: ram_wr_data[15:0]};
  assign rd_en = ram_ce & ~ram_wr_en;

  // Only byte lanes 0/1 and address bits [3:2] carry meaning here.
  logic unused_bits;
  assign unused_bits = ^{ram_addr[31:4], ram_addr[1:0], ram_addr_sel[3:2], ram_wr_data[31:16]};

  // Baud divisor, one byte-lane register per writable lane
  logic [1:0][7:0] div_lanes;
  logic [15:0]     div;
  logic            baud_wr;

  assign baud_wr = req.wr && (req.reg_sel == REG_BAUD);
  assign div     = div_lanes;

  for (genvar i = 0; i < 2; i++) begin : g_div
    uart_tx_port_div_lane #(.RST_VAL(DEFAULT_DIV[8*i +: 8])) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (baud_wr & req.be[i]),
      .d     (req.wdata[8*i +: 8]),
      .q     (div_lanes[i])
    );
  end

  // Transmit FIFO
  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  logic                       fifo_empty, fifo_full;
  logic                       push, push_ok, pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign push       = req.wr && (req.reg_sel == REG_TXDATA) && req.be[0];
  // A full FIFO still takes a byte when the serializer drains one that same cycle.
  assign push_ok    = push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= req.wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a new drop beats a simultaneous clear
  logic overflow, ovf_set, ovf_clr;

  assign ovf_set = push && fifo_full && !pop;
  assign ovf_clr = req.wr && (req.reg_sel == REG_STATUS) && req.be[0] && req.wdata[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  // Serializer
  logic [1:0]  state;
  logic [15:0] cnt, bit_rld, eff_m1;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        bit_end, tx_busy;

  assign eff_m1  = (div == 16'd0) ? 16'd0 : div - 16'd1;
  assign bit_end = (cnt == 16'd0);
  assign tx_busy = (state != S_IDLE);
  assign pop     = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

  // uart_txd is registered alongside the state so the line never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      uart_txd <= 1'b1;
      cnt      <= 16'd0;
      bit_rld  <= 16'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state    <= S_START;
            uart_txd <= 1'b0;
            shreg    <= mem[rd_ptr];
            bit_rld  <= eff_m1;
            cnt      <= eff_m1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state    <= S_DATA;
            uart_txd <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            bit_idx  <= 3'd0;
            cnt      <= bit_rld;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt <= bit_rld;
            if (bit_idx == 3'd7) begin
              state    <= S_STOP;
              uart_txd <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              uart_txd <= shreg[0];
              shreg    <= {1'b0, shreg[7:1]};
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (pop) begin
              state    <= S_START;
              uart_txd <= 1'b0;
              shreg    <= mem[rd_ptr];
              bit_rld  <= eff_m1;
              cnt      <= eff_m1;
            end else begin
              state    <= S_IDLE;
              uart_txd <= 1'b1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state    <= S_IDLE;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    ram_data_in = 32'h0;
    if (rd_en) begin
      case (ram_addr[3:2])
        REG_STATUS: ram_data_in = {28'h0, overflow, fifo_empty, fifo_full, tx_busy};
        REG_BAUD:   ram_data_in = {16'h0, div};
        default:    ram_data_in = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: a line-waveform queue model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.

module tb_uart_tx_port;

  localparam int          DEPTH = 4;
  localparam logic [15:0] DIV0  = 16'd434;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ram_ce = 1'b0;
  logic        ram_wr_en = 1'b0;
  logic [31:0] ram_addr = 32'h0;
  logic [3:0]  ram_addr_sel = 4'h0;
  logic [31:0] ram_wr_data = 32'h0;
  logic [31:0] ram_data_in;
  logic        uart_txd;

  uart_tx_port #(.DEFAULT_DIV(DIV0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ram_ce(ram_ce), .ram_wr_en(ram_wr_en),
    .ram_addr(ram_addr), .ram_addr_sel(ram_addr_sel), .ram_wr_data(ram_wr_data),
    .ram_data_in(ram_data_in), .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit rec     = 1'b0;
  bit trace[$];
  int runs[$];

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model: FIFO as a byte queue, the line as a queue of per-cycle levels.
  byte unsigned mq[$];
  bit           ml[$];
  bit           m_ovf = 1'b0, m_busy = 1'b0, m_txd = 1'b1;
  logic [15:0]  m_div = DIV0;
  bit           m_popped, m_set, m_clr;
  int           m_pre, m_eff;
  logic [9:0]   m_fr;
  logic [7:0]   m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); ml.delete();
      m_ovf = 1'b0; m_busy = 1'b0; m_txd = 1'b1; m_div = DIV0;
    end else begin
      m_pre = mq.size(); m_popped = 1'b0; m_set = 1'b0; m_clr = 1'b0;
      if (ml.size() == 0 && m_pre > 0) begin
        m_b = mq.pop_front();
        m_fr = {1'b1, m_b, 1'b0};
        m_popped = 1'b1;
        m_eff = (m_div == 16'd0) ? 1 : int'(m_div);
        for (int b = 0; b < 10; b++)
          for (int k = 0; k < m_eff; k++) ml.push_back(m_fr[b]);
      end
      if (ml.size() > 0) begin m_txd = ml.pop_front(); m_busy = 1'b1; end
      else begin m_txd = 1'b1; m_busy = 1'b0; end
      if (ram_ce && ram_wr_en) begin
        case (ram_addr[3:2])
          2'd0: if (ram_addr_sel[0]) begin
                  if (m_pre == DEPTH && !m_popped) m_set = 1'b1;
                  else mq.push_back(ram_wr_data[7:0]);
                end
          2'd1: m_clr = ram_addr_sel[0] && ram_wr_data[3];
          2'd2: begin
                  if (ram_addr_sel[0]) m_div[7:0]  = ram_wr_data[7:0];
                  if (ram_addr_sel[1]) m_div[15:8] = ram_wr_data[15:8];
                end
          default: ;
        endcase
      end
      if (m_set) m_ovf = 1'b1;
      else if (m_clr) m_ovf = 1'b0;
    end
  end

  logic [31:0] exp_rd;
  always @(negedge clk) begin
    if (chk_en) begin
      check("txd_model", uart_txd, m_txd);
      exp_rd = 32'h0;
      if (ram_ce && !ram_wr_en) begin
        case (ram_addr[3:2])
          2'd1: exp_rd = {28'h0, m_ovf, mq.size() == 0, mq.size() == DEPTH, m_busy};
          2'd2: exp_rd = {16'h0, m_div};
          default: exp_rd = 32'h0;
        endcase
      end
      check("rdata_model", ram_data_in, exp_rd);
      if (rec) trace.push_back(uart_txd);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(logic [1:0] a, logic [3:0] be, logic [31:0] d);
    ram_ce = 1'b1; ram_wr_en = 1'b1;
    ram_addr = $urandom(); ram_addr[3:2] = a;
    ram_addr_sel = be; ram_wr_data = d;
    tick();
    ram_ce = 1'b0; ram_wr_en = 1'b0;
  endtask

  task automatic rd(logic [1:0] a, output logic [31:0] v);
    ram_ce = 1'b1; ram_wr_en = 1'b0;
    ram_addr = $urandom(); ram_addr[3:2] = a;
    #1;
    v = ram_data_in;
    ram_ce = 1'b0;
  endtask

  task automatic wait_idle(string nm, int budget);
    logic [31:0] v;
    for (int i = 0; i < budget; i++) begin
      rd(2'd1, v);
      if (v[2:0] == 3'b100) break;
      tick();
    end
    check(nm, v[2:0], 3'b100);
  endtask

  task automatic low_runs();
    int n;
    runs.delete(); n = 0;
    foreach (trace[i]) begin
      if (trace[i] == 1'b0) n++;
      else if (n > 0) begin runs.push_back(n); n = 0; end
    end
    if (n > 0) runs.push_back(n);
  endtask

  function automatic int find_low(int from);
    for (int i = from; i < trace.size(); i++) if (trace[i] == 1'b0) return i;
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] v;
  logic [9:0]  fr;
  logic [39:0] wact, wexp;
  int          s, zeros, last;

  initial begin
    #3 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    tick();
    chk_en = 1'b1;

    // Reset state
    rd(2'd1, v); check("rst_status", v, 32'h4);
    rd(2'd2, v); check("rst_baud", v, 32'd434);
    rd(2'd0, v); check("rst_txdata", v, 32'h0);
    check("rst_idle_rdata", ram_data_in, 32'h0);
    check("rst_txd", uart_txd, 1'b1);

    // 0xA5 at div 4
    wr(2'd2, 4'b0011, 32'd4);
    trace.delete(); rec = 1'b1;
    wr(2'd0, 4'b0001, 32'hFFFF_FFA5);
    for (int i = 0; i < 45; i++) begin
      tick();
      if (i == 20) begin rd(2'd1, v); check("a5_status_mid", v, 32'h5); end
    end
    rec = 1'b0;
    s = find_low(0);
    check("a5_latency", s, 2);
    fr = {1'b1, 8'hA5, 1'b0};
    wact = '0;
    for (int j = 0; j < 40; j++) begin
      wexp[j] = fr[j/4];
      if (s >= 0 && s + j < trace.size()) wact[j] = trace[s+j];
    end
    check("a5_wave", wact, wexp);
    check("a5_after", (s >= 0 && s + 40 < trace.size()) ? trace[s+40] : 1'b0, 1'b1);
    rd(2'd1, v); check("a5_status_end", v, 32'h4);

    // Five back-to-back pushes at div 2, all zero bytes
    wr(2'd2, 4'b0011, 32'd2);
    trace.delete(); rec = 1'b1;
    for (int i = 0; i < 5; i++) wr(2'd0, 4'b0001, 32'h0);
    rd(2'd1, v); check("b2b_no_ovf", v[3], 1'b0);
    repeat (110) tick();
    rec = 1'b0;
    s = find_low(0); zeros = 0; last = -1;
    foreach (trace[i]) if (trace[i] == 1'b0) begin zeros++; last = i; end
    check("b2b_zero_cycles", zeros, 90);
    check("b2b_span", last - s + 1, 98);

    // Overflow while a frame is in flight
    wr(2'd2, 4'b0011, 32'd4);
    for (int i = 0; i < 6; i++) wr(2'd0, 4'b0001, 32'h30 + i);
    rd(2'd1, v); check("ovf_status", v, 32'h0B);
    wr(2'd1, 4'b0001, 32'h8);
    rd(2'd1, v); check("ovf_cleared", v, 32'h03);
    wait_idle("ovf_drain", 400);

    // Lane-1-only divisor write keeps low byte
    wr(2'd2, 4'b0010, 32'h0000_1200);
    rd(2'd2, v); check("baud_lane1", v, 32'h1204);
    wr(2'd2, 4'b1111, 32'hABCD_0000);
    rd(2'd2, v); check("baud_zero", v, 32'h0);
    wr(2'd3, 4'b1111, 32'hFFFF_FFFF);
    rd(2'd2, v); check("reserved_wr", v, 32'h0);
    trace.delete(); rec = 1'b1;
    wr(2'd0, 4'b0001, 32'h00);
    repeat (15) tick();
    rec = 1'b0;
    low_runs();
    check("div0_run", runs.size() > 0 ? runs[0] : -1, 9);

    // Divisor change mid-frame takes effect on the next frame
    wr(2'd2, 4'b0011, 32'd2);
    trace.delete(); rec = 1'b1;
    wr(2'd0, 4'b0001, 32'hFF);
    wr(2'd0, 4'b0001, 32'hFF);
    wr(2'd2, 4'b0011, 32'h0010);
    repeat (200) tick();
    rec = 1'b0;
    low_runs();
    check("mid_nruns", runs.size(), 2);
    check("mid_run0", runs.size() > 0 ? runs[0] : -1, 2);
    check("mid_run1", runs.size() > 1 ? runs[1] : -1, 16);
    wait_idle("mid_drain", 200);

    // Reset during data bit 3 of 0x52 with another byte queued
    wr(2'd2, 4'b0011, 32'd4);
    wr(2'd0, 4'b0001, 32'h52);
    wr(2'd0, 4'b0001, 32'h77);
    repeat (17) tick();
    check("rst_mid_pre", uart_txd, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_txd", uart_txd, 1'b1);
    tick(); tick();
    rst_n = 1'b1;
    rd(2'd1, v); check("rst_mid_status", v, 32'h4);
    rd(2'd2, v); check("rst_mid_baud", v, 32'd434);
    trace.delete(); rec = 1'b1;
    repeat (60) tick();
    rec = 1'b0;
    zeros = 0;
    foreach (trace[i]) if (trace[i] == 1'b0) zeros++;
    check("rst_mid_quiet", zeros, 0);

    // Randomized traffic
    wr(2'd2, 4'b0011, 32'd2);
    for (int it = 0; it < 3000; it++) begin
      int r;
      logic [1:0] a;
      r = $urandom_range(0, 99);
      ram_addr = $urandom();
      ram_addr_sel = 4'($urandom());
      if (r < 35) begin
        ram_ce = 1'b0;
      end else if (r < 60) begin
        ram_ce = 1'b1; ram_wr_en = 1'b0;
      end else begin
        a = 2'($urandom_range(0, 3));
        ram_addr[3:2] = a;
        ram_ce = 1'b1; ram_wr_en = 1'b1;
        ram_wr_data = (a == 2'd2) ? 32'($urandom_range(0, 5)) : $urandom();
      end
      tick();
      ram_ce = 1'b0; ram_wr_en = 1'b0;
    end
    wait_idle("rand_drain", 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
